// File: rtl/rsfq_nott_array.sv
// Behavioural N-channel RSFQ clocked NOT / buffered-DFF array with per-channel timing-window checks.
// Every clk or in edge is one SFQ pulse; a violation forces out[c] to X, sets err[c] and bumps a saturating count.
module rsfq_nott_array #(
    parameter int  N             = 4,
    parameter bit  INVERT        = 1'b1,
    parameter real DELAY_CLK_OUT = 14.0,
    parameter real CT_CLK_IN     = 7.4,
    parameter real CT_CLK_CLK    = 15.9,
    parameter real CT_IN_CLK     = 10.9,
    parameter int  CNT_W         = 8,
    parameter bit  LOG_EN        = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in,
    output logic [N-1:0]     out,
    output logic [N-1:0]     err,
    output logic [CNT_W-1:0] err_count
);
    timeunit 1ps;
    timeprecision 100fs;

    // Guards real compares so an edge landing exactly on a window expiry stays legal.
    localparam real              EPS     = 1.0e-6;
    localparam real              DUE_TOL = 0.05;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {IDLE, ARMED} ch_state_t;

    ch_state_t        st_q       [N];
    real              in_exp_q   [N];
    real              clk_exp_q  [N];
    real              last_in_q  [N];
    real              due_q      [N];
    real              last_clk_q;
    logic [N-1:0]     pend_q;
    logic [N-1:0]     out_raw_q;
    logic [N-1:0]     xmask_q;
    logic [N-1:0]     err_q;
    logic [N-1:0]     in_prev_q;
    logic [N-1:0]     tog_ev_q;
    logic [N-1:0]     tog_prev_q;
    logic             clk_prev_q;
    logic             rst_prev_q;
    logic [CNT_W-1:0] cnt_q;

    assign out       = (out_raw_q & ~xmask_q) | ({N{1'bx}} & xmask_q);
    assign err       = err_q;
    assign err_count = cnt_q;

    task automatic violate(input int c);
        xmask_q[c] = 1'b1;
        err_q[c]   = 1'b1;
        if (cnt_q != CNT_MAX) cnt_q = cnt_q + 1'b1;
        if (LOG_EN) begin
            $display("%m: channel %0d timing violation at %0t", c, $realtime);
        end
    endtask

    // Records a pending output pulse and opens (or extends) both blocking windows.
    task automatic emit_pulse(input int c, input real now);
        pend_q[c] = 1'b1;
        due_q[c]  = now + DELAY_CLK_OUT;
        if (now + CT_CLK_IN > in_exp_q[c])   in_exp_q[c]  = now + CT_CLK_IN;
        if (now + CT_CLK_CLK > clk_exp_q[c]) clk_exp_q[c] = now + CT_CLK_CLK;
    endtask

    task automatic handle_in(input int c, input real now);
        if (last_clk_q == now || now < in_exp_q[c] - EPS) begin
            violate(c);
        end else if (st_q[c] == IDLE) begin
            st_q[c] = ARMED;
        end else if (now + CT_IN_CLK > clk_exp_q[c]) begin
            clk_exp_q[c] = now + CT_IN_CLK;
        end
        last_in_q[c] = now;
    endtask

    task automatic handle_clk(input int c, input real now, inout logic [N-1:0] emit);
        if (last_in_q[c] == now || now < clk_exp_q[c] - EPS) begin
            violate(c);
        end else if (INVERT) begin
            if (st_q[c] == IDLE) begin
                emit[c] = 1'b1;
                emit_pulse(c, now);
            end else begin
                st_q[c] = IDLE;
            end
        end else if (st_q[c] == ARMED) begin
            emit[c] = 1'b1;
            emit_pulse(c, now);
            st_q[c] = IDLE;
        end
    endtask

    // Single event process: matured output pulses, reset, then clk/in edges of this timestep.
    always begin : pulse_engine
        real          now;
        real          diff;
        logic [N-1:0] in_edge;
        logic [N-1:0] tog_edge;
        logic [N-1:0] emit;
        logic         clk_edge;
        @(clk or in or rst_n or tog_ev_q);
        now      = $realtime;
        emit     = '0;
        in_edge  = '0;
        tog_edge = '0;
        clk_edge = 1'b0;
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                st_q[c]      = IDLE;
                in_exp_q[c]  = 0.0;
                clk_exp_q[c] = 0.0;
                last_in_q[c] = -1.0;
                due_q[c]     = -1.0;
            end
            last_clk_q = -1.0;
            pend_q     = '0;
            out_raw_q  = '0;
            xmask_q    = '0;
            err_q      = '0;
            cnt_q      = '0;
            tog_ev_q  <= '0;
        end else begin
            tog_edge = tog_ev_q ^ tog_prev_q;
            for (int c = 0; c < N; c++) begin
                diff = (now > due_q[c]) ? now - due_q[c] : due_q[c] - now;
                if (tog_edge[c] && pend_q[c] && diff < DUE_TOL) begin
                    pend_q[c]    = 1'b0;
                    out_raw_q[c] = ~out_raw_q[c];
                end
            end
            // Edges that coincide with the release of reset are ignored.
            if (rst_prev_q) begin
                clk_edge = (clk !== clk_prev_q);
                in_edge  = in ^ in_prev_q;
                for (int c = 0; c < N; c++) begin
                    if (clk_edge && in_edge[c]) begin
                        violate(c);
                        last_in_q[c] = now;
                    end else begin
                        if (in_edge[c]) handle_in(c, now);
                        if (clk_edge)   handle_clk(c, now, emit);
                    end
                end
                if (clk_edge) last_clk_q = now;
                if (emit != '0) tog_ev_q <= #(DELAY_CLK_OUT) tog_ev_q ^ emit;
            end
        end
        clk_prev_q = clk;
        in_prev_q  = in;
        rst_prev_q = rst_n;
        tog_prev_q = tog_ev_q;
    end

endmodule

// File: tb/tb_rsfq_nott_array.sv
// Directed timing bench for rsfq_nott_array: NOT array (dut) and DFF array with 2-bit counter (dut2).
module tb_rsfq_nott_array;
    timeunit 1ps;
    timeprecision 100fs;

    logic       clk, clk2, rst_n;
    logic [3:0] in, in2;
    logic [3:0] out, out2, err, err2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic       x2;
    int         n_chk;
    int         n_pass;

    rsfq_nott_array #(.N(4), .INVERT(1'b1), .CNT_W(8), .LOG_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .out(out), .err(err), .err_count(err_count)
    );

    rsfq_nott_array #(.N(4), .INVERT(1'b0), .CNT_W(2), .LOG_EN(1'b0)) dut2 (
        .clk(clk2), .rst_n(rst_n), .in(in2), .out(out2), .err(err2), .err_count(err_count2)
    );

    task automatic wait_until(input real t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic test_reset();
        clk = 1'b0; clk2 = 1'b0; in = '0; in2 = '0; rst_n = 1'b0;
        wait_until(5.0);
        n_chk++; if (out !== 4'b0000) $display("FAIL reset_out: got %b want 0000", out); else n_pass++;
        n_chk++; if (err !== 4'b0000 || err_count !== 8'd0) $display("FAIL reset_err: got %b/%0d want 0000/0", err, err_count); else n_pass++;
        wait_until(10.0);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_clk();
        wait_until(100.0); clk = ~clk;
        wait_until(113.0);
        n_chk++; if (out !== 4'b0000) $display("FAIL idle_early: got %b want 0000", out); else n_pass++;
        wait_until(115.0);
        n_chk++; if (out !== 4'b1111) $display("FAIL idle_out: got %b want 1111", out); else n_pass++;
        n_chk++; if (err !== 4'b0000 || err_count !== 8'd0) $display("FAIL idle_err: got %b/%0d want 0000/0", err, err_count); else n_pass++;
    endtask

    task automatic test_armed_hold();
        wait_until(200.0); in[1] = ~in[1];
        wait_until(300.0); clk = ~clk;
        wait_until(313.0);
        n_chk++; if (out !== 4'b1111) $display("FAIL hold_early: got %b want 1111", out); else n_pass++;
        wait_until(315.0);
        n_chk++; if (out !== 4'b0010) $display("FAIL hold_out: got %b want 0010", out); else n_pass++;
        wait_until(400.0); clk = ~clk;
        wait_until(415.0);
        n_chk++; if (out !== 4'b1101) $display("FAIL after_hold: got %b want 1101", out); else n_pass++;
    endtask

    task automatic test_in_window();
        wait_until(500.0); clk = ~clk;
        wait_until(505.0); in[2] = ~in[2];
        wait_until(506.0);
        n_chk++; if (err !== 4'b0100) $display("FAIL inwin_err: got %b want 0100", err); else n_pass++;
        n_chk++; if (err_count !== 8'd1) $display("FAIL inwin_cnt: got %0d want 1", err_count); else n_pass++;
        x2 = out[2];
        wait_until(515.0);
        n_chk++; if ((out & 4'b1011) !== 4'b0010) $display("FAIL inwin_others: got %b want x0x10", out); else n_pass++;
        wait_until(600.0); clk = ~clk;
        wait_until(615.0);
        n_chk++; if ((out & 4'b1011) !== 4'b1001) $display("FAIL post_viol_out: got %b want 1x01", out); else n_pass++;
        n_chk++; if (out[2] !== x2) $display("FAIL x_sticky: got %b want %b", out[2], x2); else n_pass++;
    endtask

    task automatic test_armed_repeat();
        wait_until(700.0); in[0] = ~in[0];
        wait_until(705.0); in[0] = ~in[0];
        wait_until(712.0); clk = ~clk;
        wait_until(713.0);
        n_chk++; if (err !== 4'b0101) $display("FAIL rep_err: got %b want 0101", err); else n_pass++;
        n_chk++; if (err_count !== 8'd2) $display("FAIL rep_cnt: got %0d want 2", err_count); else n_pass++;
        wait_until(725.0);
        n_chk++; if ((out & 4'b1010) !== 4'b1000) $display("FAIL rep_early: got %b want 1x0x", out); else n_pass++;
        wait_until(727.0);
        n_chk++; if ((out & 4'b1010) !== 4'b0010) $display("FAIL rep_others: got %b want 0x1x", out); else n_pass++;
    endtask

    task automatic test_reset_cancel();
        wait_until(800.0); clk = ~clk;
        wait_until(805.0); rst_n = 1'b0;
        wait_until(806.0);
        n_chk++; if (out !== 4'b0000) $display("FAIL rst_out: got %b want 0000", out); else n_pass++;
        n_chk++; if (err !== 4'b0000 || err_count !== 8'd0) $display("FAIL rst_err: got %b/%0d want 0000/0", err, err_count); else n_pass++;
        wait_until(810.0); rst_n = 1'b1;
        wait_until(815.0);
        n_chk++; if (out !== 4'b0000) $display("FAIL rst_cancel: got %b want 0000", out); else n_pass++;
        wait_until(900.0); clk = ~clk;
        wait_until(915.0);
        n_chk++; if (out !== 4'b1111) $display("FAIL post_rst_out: got %b want 1111", out); else n_pass++;
    endtask

    task automatic test_window_edges();
        wait_until(907.4); in[3] = ~in[3];
        wait_until(1000.0); clk = ~clk;
        wait_until(1015.0);
        n_chk++; if (out !== 4'b1000) $display("FAIL in_expiry_out: got %b want 1000", out); else n_pass++;
        n_chk++; if (err !== 4'b0000) $display("FAIL in_expiry_err: got %b want 0000", err); else n_pass++;
        wait_until(1015.9); clk = ~clk;
        wait_until(1031.0);
        n_chk++; if (out !== 4'b0111) $display("FAIL clk_expiry_out: got %b want 0111", out); else n_pass++;
        n_chk++; if (err_count !== 8'd0) $display("FAIL clk_expiry_cnt: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_dff_mode();
        wait_until(1100.0); clk2 = ~clk2;
        wait_until(1115.0);
        n_chk++; if (out2 !== 4'b0000) $display("FAIL dff_idle: got %b want 0000", out2); else n_pass++;
        wait_until(1200.0); in2[3] = ~in2[3];
        wait_until(1250.0); clk2 = ~clk2;
        wait_until(1263.0);
        n_chk++; if (out2 !== 4'b0000) $display("FAIL dff_early: got %b want 0000", out2); else n_pass++;
        wait_until(1265.0);
        n_chk++; if (out2 !== 4'b1000) $display("FAIL dff_out: got %b want 1000", out2); else n_pass++;
        wait_until(1300.0); in2[0] = ~in2[0]; clk2 = ~clk2;
        wait_until(1301.0);
        n_chk++; if (err2 !== 4'b0001 || err_count2 !== 2'd1) $display("FAIL simul: got %b/%0d want 0001/1", err2, err_count2); else n_pass++;
    endtask

    task automatic test_dff_saturate();
        wait_until(1400.0); in2[1] = ~in2[1];
        wait_until(1405.0); in2[1] = ~in2[1];
        wait_until(1410.0); clk2 = ~clk2;
        wait_until(1411.0);
        n_chk++; if (err2 !== 4'b0011 || err_count2 !== 2'd2) $display("FAIL dff_rep: got %b/%0d want 0011/2", err2, err_count2); else n_pass++;
        wait_until(1500.0); in2[2] = ~in2[2];
        wait_until(1550.0); clk2 = ~clk2;
        wait_until(1552.0); in2[2] = ~in2[2];
        wait_until(1553.0);
        n_chk++; if (err_count2 !== 2'd3) $display("FAIL sat_reach: got %0d want 3", err_count2); else n_pass++;
        wait_until(1554.0); in2[2] = ~in2[2];
        wait_until(1556.0); in2[2] = ~in2[2];
        wait_until(1557.0);
        n_chk++; if (err_count2 !== 2'd3) $display("FAIL sat_hold: got %0d want 3", err_count2); else n_pass++;
        n_chk++; if (err2 !== 4'b0111) $display("FAIL sat_err: got %b want 0111", err2); else n_pass++;
        wait_until(1565.0);
        n_chk++; if ((out2 & 4'b1000) !== 4'b1000) $display("FAIL sat_out3: got %b want 1xxx", out2); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_idle_clk();
        test_armed_hold();
        test_in_window();
        test_armed_repeat();
        test_reset_cancel();
        test_window_edges();
        test_dff_mode();
        test_dff_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
